// File: rtl/burst_mp_pkg.sv
// Shared types, defaults and width helpers for the burst master port.
package burst_mp_pkg;

  typedef enum logic [3:0] {
    IDLE, REQ, SADDR, WAIT, ADDR, SETUP, WDATA, RDATA, SPLIT, NEXT, BACKOFF
  } state_t;

  localparam int DEF_ADDR_WIDTH   = 16;
  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_MEM_WIDTH    = 12;
  localparam int DEF_MAX_BURST    = 16;
  localparam int DEF_TIMEOUT_TIME = 5;
  localparam int DEF_MAX_RETRY    = 3;
  localparam int DEF_DEV_WIDTH    = DEF_ADDR_WIDTH - DEF_MEM_WIDTH;

  // Width of a counter that must hold values 0..max_val.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int len_width(input int max_burst);
    return (max_burst < 2) ? 1 : $clog2(max_burst);
  endfunction

  function automatic int dev_width(input int addr_w, input int mem_w);
    return addr_w - mem_w;
  endfunction

endpackage

// File: rtl/mp_retry_timer.sv
// WAIT-state timeout counter and per-beat retry counter.
module mp_retry_timer
  import burst_mp_pkg::*;
#(
  parameter int TIMEOUT_TIME = DEF_TIMEOUT_TIME,
  parameter int MAX_RETRY    = DEF_MAX_RETRY
) (
  input  logic clk,
  input  logic rstn,
  input  logic waiting,
  input  logic retry_inc,
  input  logic clear,
  output logic expired,
  output logic exhausted
);

  localparam int TW = cnt_width(TIMEOUT_TIME);
  localparam int RW = cnt_width(MAX_RETRY);

  logic [TW-1:0] tmo_q, tmo_d;
  logic [RW-1:0] retry_q, retry_d;

  assign expired   = waiting && (tmo_q == TW'(TIMEOUT_TIME - 1));
  assign exhausted = (retry_q == RW'(MAX_RETRY));

  // The timeout restarts on every entry into WAIT.
  always_comb begin
    tmo_d   = '0;
    retry_d = retry_q;
    if (waiting && !expired) tmo_d = tmo_q + 1'b1;
    if (clear) retry_d = '0;
    else if (retry_inc && !exhausted) retry_d = retry_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tmo_q   <= '0;
      retry_q <= '0;
    end else begin
      tmo_q   <= tmo_d;
      retry_q <= retry_d;
    end
  end

endmodule

// File: rtl/burst_master_port.sv
// Multi-beat serial-bus master: holds the bus for a whole burst and shifts
// device field, memory field and data bit-serially per beat.
module burst_master_port
  import burst_mp_pkg::*;
#(
  parameter int ADDR_WIDTH           = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH           = DEF_DATA_WIDTH,
  parameter int SLAVE_MEM_ADDR_WIDTH = DEF_MEM_WIDTH,
  parameter int MAX_BURST            = DEF_MAX_BURST,
  parameter int TIMEOUT_TIME         = DEF_TIMEOUT_TIME,
  parameter int MAX_RETRY            = DEF_MAX_RETRY,
  localparam int LEN_W               = len_width(MAX_BURST)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] dwdata,
  input  logic [ADDR_WIDTH-1:0] daddr,
  input  logic [LEN_W-1:0]      dlen,
  input  logic                  dmode,
  input  logic                  dvalid,
  output logic                  dready,
  output logic                  dnext,
  output logic [DATA_WIDTH-1:0] drdata,
  output logic                  drvalid,
  output logic                  ddone,
  output logic                  derr,
  input  logic                  mrdata,
  input  logic                  svalid,
  output logic                  mwdata,
  output logic                  mvalid,
  output logic                  mmode,
  output logic                  mbreq,
  input  logic                  mbgrant,
  input  logic                  msplit,
  input  logic                  ack
);

  localparam int MEM_W  = SLAVE_MEM_ADDR_WIDTH;
  localparam int DEV_W  = dev_width(ADDR_WIDTH, SLAVE_MEM_ADDR_WIDTH);
  localparam int MAX_AD = (DEV_W > MEM_W) ? DEV_W : MEM_W;
  localparam int SH_W   = (MAX_AD > DATA_WIDTH) ? MAX_AD : DATA_WIDTH;
  localparam int BIT_W  = cnt_width(SH_W);

  state_t                state_q, state_d;
  logic [DEV_W-1:0]      dev_q, dev_d;
  logic [MEM_W-1:0]      mem_q, mem_d;
  logic [LEN_W-1:0]      len_q, len_d, beat_q, beat_d;
  logic                  mode_q, mode_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rbuf_q, rbuf_d, drdata_q, drdata_d;
  logic                  drvalid_q, drvalid_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [SH_W-1:0]       sh_q, sh_d;
  logic                  mwdata_q, mwdata_d, mvalid_q, mvalid_d;
  logic                  retry_inc, retry_clr, expired, exhausted, last_beat;

  mp_retry_timer #(
    .TIMEOUT_TIME(TIMEOUT_TIME),
    .MAX_RETRY   (MAX_RETRY)
  ) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .waiting  (state_q == WAIT),
    .retry_inc(retry_inc),
    .clear    (retry_clr),
    .expired  (expired),
    .exhausted(exhausted)
  );

  assign dready  = (state_q == IDLE);
  assign mbreq   = (state_q != IDLE) && (state_q != BACKOFF);
  assign mmode   = mode_q;
  assign mwdata  = mwdata_q;
  assign mvalid  = mvalid_q;
  assign drdata  = drdata_q;
  assign drvalid = drvalid_q;

  // Each serial field is loaded into sh_q on the edge entering its shift state.
  always_comb begin
    state_d   = state_q;
    dev_d     = dev_q;
    mem_d     = mem_q;
    len_d     = len_q;
    beat_d    = beat_q;
    mode_d    = mode_q;
    wdata_d   = wdata_q;
    rbuf_d    = rbuf_q;
    drdata_d  = drdata_q;
    drvalid_d = 1'b0;
    bit_d     = bit_q;
    sh_d      = sh_q;
    mvalid_d  = 1'b0;
    mwdata_d  = 1'b0;
    retry_inc = 1'b0;
    retry_clr = 1'b0;
    ddone     = 1'b0;
    derr      = 1'b0;
    dnext     = 1'b0;
    last_beat = (beat_q == len_q);
    unique case (state_q)
      IDLE: begin
        retry_clr = 1'b1;
        if (dvalid) begin
          dev_d   = daddr[ADDR_WIDTH-1 -: DEV_W];
          mem_d   = daddr[MEM_W-1:0];
          len_d   = dlen;
          mode_d  = dmode;
          wdata_d = dwdata;
          beat_d  = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mbgrant) begin
          sh_d    = SH_W'(dev_q);
          bit_d   = '0;
          state_d = SADDR;
        end
      end
      SADDR: begin
        mvalid_d = 1'b1;
        mwdata_d = sh_q[0];
        sh_d     = sh_q >> 1;
        bit_d    = bit_q + 1'b1;
        if (bit_q == BIT_W'(DEV_W - 1)) begin
          bit_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (ack) begin
          sh_d    = SH_W'(mem_q);
          bit_d   = '0;
          state_d = ADDR;
        end else if (expired) begin
          if (!exhausted) begin
            retry_inc = 1'b1;
            state_d   = BACKOFF;
          end else begin
            ddone   = 1'b1;
            derr    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      BACKOFF: state_d = REQ;
      ADDR: begin
        mvalid_d = 1'b1;
        mwdata_d = sh_q[0];
        sh_d     = sh_q >> 1;
        bit_d    = bit_q + 1'b1;
        if (bit_q == BIT_W'(MEM_W - 1)) begin
          bit_d   = '0;
          state_d = mode_q ? SETUP : RDATA;
        end
      end
      SETUP: begin
        sh_d    = SH_W'(wdata_q);
        bit_d   = '0;
        state_d = WDATA;
      end
      WDATA: begin
        mvalid_d = 1'b1;
        mwdata_d = sh_q[0];
        sh_d     = sh_q >> 1;
        bit_d    = bit_q + 1'b1;
        if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
          bit_d   = '0;
          state_d = NEXT;
        end
      end
      // A split takes priority over a bit arriving in the same cycle.
      RDATA: begin
        if (msplit) begin
          state_d = SPLIT;
        end else if (svalid) begin
          rbuf_d = (rbuf_q >> 1) | (DATA_WIDTH'(mrdata) << (DATA_WIDTH - 1));
          bit_d  = bit_q + 1'b1;
          if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
            drdata_d  = rbuf_d;
            drvalid_d = 1'b1;
            bit_d     = '0;
            state_d   = NEXT;
          end
        end
      end
      SPLIT: begin
        if (!msplit && mbgrant) state_d = RDATA;
      end
      NEXT: begin
        if (last_beat) begin
          ddone   = 1'b1;
          state_d = IDLE;
        end else begin
          mem_d     = mem_q + 1'b1;
          beat_d    = beat_q + 1'b1;
          retry_clr = 1'b1;
          bit_d     = '0;
          if (mode_q) begin
            dnext   = 1'b1;
            wdata_d = dwdata;
          end
          if (mbgrant) begin
            sh_d    = SH_W'(dev_q);
            state_d = SADDR;
          end else begin
            state_d = REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rstn) begin
      ddone = 1'b0;
      derr  = 1'b0;
      dnext = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      dev_q     <= '0;
      mem_q     <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      mode_q    <= 1'b0;
      wdata_q   <= '0;
      rbuf_q    <= '0;
      drdata_q  <= '0;
      drvalid_q <= 1'b0;
      bit_q     <= '0;
      sh_q      <= '0;
      mwdata_q  <= 1'b0;
      mvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      dev_q     <= dev_d;
      mem_q     <= mem_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      mode_q    <= mode_d;
      wdata_q   <= wdata_d;
      rbuf_q    <= rbuf_d;
      drdata_q  <= drdata_d;
      drvalid_q <= drvalid_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      mwdata_q  <= mwdata_d;
      mvalid_q  <= mvalid_d;
    end
  end

endmodule
